// File: rtl/mil_word_transmitter_pkg.sv
// Shared MIL-STD-1553 word types and frame constants for the mil push path.
package milStd1553;

  typedef enum logic [1:0] {
    WERROR   = 2'd0,
    WCOMMAND = 2'd1,
    WSTATUS  = 2'd2,
    WDATA    = 2'd3
  } WordType;

  localparam int SYNC_HALFBITS = 6;
  localparam int DATA_HALFBITS = 34;

  // Half-bit line levels of the sync field, first half-bit in the MSB.
  localparam logic [SYNC_HALFBITS-1:0] SYNC_CMD_PAT = 6'b111_000;
  localparam logic [SYNC_HALFBITS-1:0] SYNC_DAT_PAT = 6'b000_111;

  function automatic logic odd_parity(input logic [15:0] w);
    return ~^w;
  endfunction

endpackage

// File: rtl/mil_word_transmitter_halfbit_strobe.sv
// Half-bit timebase: counts clk cycles within a half-bit and pulses on wrap.
module mil_halfbit_strobe #(
  parameter int CLK_PER_HALFBIT = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic en_i,
  output logic strobe_o
);

  localparam int CW = $clog2(CLK_PER_HALFBIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_HALFBIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign strobe_o = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)       cnt_d = '0;
    else if (strobe_o) cnt_d = '0;
    else if (en_i)     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mil_word_transmitter.sv
// Serialises one 1553 word per IPushMil handshake as Manchester-II on line_p/line_n.
module mil_word_transmitter
  import milStd1553::*;
#(
  parameter int CLK_PER_HALFBIT = 12,
  parameter int GAP_HALFBITS    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mil_request,
  input  logic [1:0]  mil_data_type,
  input  logic [15:0] mil_data_word,
  output logic        mil_done,
  output logic        line_p,
  output logic        line_n,
  output logic        tx_busy
);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, GAP, REPORT} state_e;

  localparam int IDX_MAX = (GAP_HALFBITS > DATA_HALFBITS) ? GAP_HALFBITS : DATA_HALFBITS;
  localparam int IDX_W   = $clog2(IDX_MAX + 1);
  localparam logic [IDX_W-1:0] SYNC_LAST = IDX_W'(SYNC_HALFBITS - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_HALFBITS - 1);
  localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'((GAP_HALFBITS > 0) ? GAP_HALFBITS - 1 : 0);

  state_e          state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [15:0]     word_q, word_d;
  logic            cmd_q, cmd_d;
  logic            done_q, done_d;
  logic            p_q, p_d, n_q, n_d;
  logic            busy_q, busy_d;
  logic            start, hb_en, hb_stb;

  logic [SYNC_HALFBITS-1:0] sync_sh;
  logic [16:0]              frame_sh;
  logic                     drive, lvl;

  assign hb_en = (state_q == SYNC) || (state_q == DATA) || (state_q == GAP);

  mil_halfbit_strobe #(.CLK_PER_HALFBIT(CLK_PER_HALFBIT)) u_strobe (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .en_i     (hb_en),
    .strobe_o (hb_stb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    cmd_d   = cmd_q;
    done_d  = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mil_request) begin
          start  = 1'b1;
          idx_d  = '0;
          word_d = mil_data_word;
          // Anything not recognised as command/status (including X) gets the data sync.
          if (mil_data_type == WCOMMAND || mil_data_type == WSTATUS) cmd_d = 1'b1;
          else                                                        cmd_d = 1'b0;
          if (mil_data_type == WERROR) begin
            state_d = REPORT;
            done_d  = 1'b1;
          end else begin
            state_d = SYNC;
          end
        end
      end
      SYNC: begin
        if (hb_stb) begin
          if (idx_q == SYNC_LAST) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (hb_stb) begin
          if (idx_q == DATA_LAST) begin
            idx_d = '0;
            if (GAP_HALFBITS == 0) begin
              state_d = REPORT;
              done_d  = 1'b1;
            end else begin
              state_d = GAP;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (hb_stb) begin
          if (idx_q == GAP_LAST) begin
            state_d = REPORT;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line levels are computed from next-state values so the registered pins
  // change on the same edge as the half-bit boundary.
  always_comb begin
    sync_sh  = (cmd_d ? SYNC_CMD_PAT : SYNC_DAT_PAT) << idx_d;
    frame_sh = {word_d, odd_parity(word_d)} << idx_d[IDX_W-1:1];
    drive    = 1'b0;
    lvl      = 1'b0;
    if (state_d == SYNC) begin
      drive = 1'b1;
      lvl   = sync_sh[SYNC_HALFBITS-1];
    end else if (state_d == DATA) begin
      drive = 1'b1;
      lvl   = frame_sh[16] ^ idx_d[0];
    end
    p_d    = drive & lvl;
    n_d    = drive & ~lvl;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      cmd_q   <= 1'b0;
      done_q  <= 1'b0;
      p_q     <= 1'b0;
      n_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      cmd_q   <= cmd_d;
      done_q  <= done_d;
      p_q     <= p_d;
      n_q     <= n_d;
      busy_q  <= busy_d;
    end
  end

  assign mil_done = done_q;
  assign line_p   = p_q;
  assign line_n   = n_q;
  assign tx_busy  = busy_q;

endmodule

// File: tb/tb_mil_word_transmitter.sv
// Bench for mil_word_transmitter: per-cycle waveform against a half-bit level model.
module tb_mil_word_transmitter;
  import milStd1553::*;

  localparam int H = 12;
  localparam int G = 4;
  localparam int WORD_LAT = (40 + G) * H + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mil_request = 1'b0;
  logic [1:0]  mil_data_type = 2'd0;
  logic [15:0] mil_data_word = 16'd0;
  logic        mil_done, line_p, line_n, tx_busy;

  int checks = 0;
  int failures = 0;

  mil_word_transmitter #(.CLK_PER_HALFBIT(H), .GAP_HALFBITS(G)) dut (
    .clk           (clk),
    .rst           (rst),
    .mil_request   (mil_request),
    .mil_data_type (mil_data_type),
    .mil_data_word (mil_data_word),
    .mil_done      (mil_done),
    .line_p        (line_p),
    .line_n        (line_n),
    .tx_busy       (tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected {done, busy, line_p, line_n} in cycle c after the request edge.
  function automatic logic [3:0] model(input logic [1:0] t, input logic [15:0] w, input int c);
    int hb, d;
    logic b, lvl;
    logic [15:0] sh;
    if (t == 2'd0) return (c == 1) ? 4'b1100 : 4'b0000;
    if (c > WORD_LAT) return 4'b0000;
    if (c == WORD_LAT) return 4'b1100;
    hb = (c - 1) / H;
    if (hb >= 40) return 4'b0100;
    if (hb < 6) begin
      if (t == 2'd1 || t == 2'd2) lvl = (hb < 3);
      else                        lvl = (hb >= 3);
    end else begin
      d = hb - 6;
      if (d / 2 < 16) begin
        sh = w >> (15 - d / 2);
        b  = sh[0];
      end else begin
        b = ~^w;
      end
      lvl = (d % 2 == 0) ? b : ~b;
    end
    return {2'b01, lvl, ~lvl};
  endfunction

  // Entered at a negedge with the DUT idle; leaves at the negedge of the cycle after mil_done.
  task automatic run_word(input logic [1:0] t, input logic [15:0] w, input int inj,
                          output int lat, output int first_p, output int par_p);
    int total, nerr, bad_c;
    logic [3:0] a, e, ba, be;
    total = (t == 2'd0) ? 2 : WORD_LAT + 1;
    nerr = 0; bad_c = 0; ba = '0; be = '0;
    lat = -1; first_p = -1; par_p = -1;
    mil_request   = 1'b1;
    mil_data_type = t;
    mil_data_word = w;
    @(negedge clk);
    mil_request   = 1'b0;
    mil_data_type = 2'($urandom);
    mil_data_word = 16'($urandom);
    for (int c = 1; c <= total; c++) begin
      a = {mil_done, tx_busy, line_p, line_n};
      e = model(t, w, c);
      if (a !== e) begin
        if (nerr == 0) begin bad_c = c; ba = a; be = e; end
        nerr++;
      end
      if (mil_done && lat < 0) lat = c;
      if (c == 1) first_p = int'(line_p);
      if (c == 38 * H + 1) par_p = int'(line_p);
      if (c == inj) begin
        mil_request   = 1'b1;
        mil_data_type = WCOMMAND;
        mil_data_word = ~w;
      end else begin
        mil_request = 1'b0;
      end
      if (c < total) @(negedge clk);
    end
    mil_request = 1'b0;
    checks++;
    if (nerr != 0) begin
      failures++;
      $display("FAIL wave t=%0d w=%h: %0d bad cycles, first at c=%0d got %b expected %b",
               t, w, nerr, bad_c, ba, be);
    end
  endtask

  typedef struct {
    logic [1:0]  t;
    logic [15:0] w;
    int          lat;
    int          fp;
    int          pp;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int lat, fp, pp, seen;
    logic [1:0] rt;
    logic [15:0] rw;

    vecs[0] = '{WCOMMAND, 16'h0C21, WORD_LAT, 1, 1};
    vecs[1] = '{WDATA,    16'h0001, WORD_LAT, 0, 0};
    vecs[2] = '{WSTATUS,  16'hFFFF, WORD_LAT, 1, 1};
    vecs[3] = '{WERROR,   16'h1234, 1,        0, 0};

    repeat (3) @(negedge clk);
    chk("reset_done", int'(mil_done), 0);
    chk("reset_p",    int'(line_p),   0);
    chk("reset_n",    int'(line_n),   0);
    chk("reset_busy", int'(tx_busy),  0);
    rst = 1'b0;
    @(negedge clk);

    // Table words run back-to-back: each request lands in the cycle after mil_done.
    for (int i = 0; i < 4; i++) begin
      run_word(vecs[i].t, vecs[i].w, 0, lat, fp, pp);
      chk($sformatf("latency[%0d]", i), lat, vecs[i].lat);
      if (vecs[i].t != WERROR) begin
        chk($sformatf("sync_first[%0d]", i), fp, vecs[i].fp);
        chk($sformatf("parity_first[%0d]", i), pp, vecs[i].pp);
      end
    end

    // Request mid-DATA (half-bit 10) must not disturb the word in flight.
    run_word(WDATA, 16'hA5C3, 16 * H + 5, lat, fp, pp);
    chk("ignored_mid_data_lat", lat, WORD_LAT);
    // Request in the REPORT cycle is dropped, not queued.
    run_word(WCOMMAND, 16'h5A5A, WORD_LAT, lat, fp, pp);
    chk("ignored_report_lat", lat, WORD_LAT);
    run_word(WSTATUS, 16'h8000, 0, lat, fp, pp);
    chk("back_to_back_lat", lat, WORD_LAT);

    // Reset at DATA half-bit 10.
    @(negedge clk);
    mil_request = 1'b1; mil_data_type = WSTATUS; mil_data_word = 16'h1357;
    @(negedge clk);
    mil_request = 1'b0;
    repeat (16 * H) @(negedge clk);
    chk("pre_reset_busy", int'(tx_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_p",    int'(line_p),   0);
    chk("abort_n",    int'(line_n),   0);
    chk("abort_busy", int'(tx_busy),  0);
    chk("abort_done", int'(mil_done), 0);
    rst = 1'b0;
    seen = 0;
    repeat (WORD_LAT + 4) begin
      @(negedge clk);
      if (mil_done || tx_busy || line_p || line_n) seen++;
    end
    chk("abort_quiet_cycles", seen, 0);
    run_word(WCOMMAND, 16'h0C21, 0, lat, fp, pp);
    chk("after_abort_lat", lat, WORD_LAT);

    for (int i = 0; i < 8; i++) begin
      rt = 2'($urandom_range(0, 3));
      rw = 16'($urandom);
      run_word(rt, rw, 0, lat, fp, pp);
      chk($sformatf("rand_lat[%0d]", i), lat, (rt == 2'd0) ? 1 : WORD_LAT);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
